// File: rtl/uds_pkg.sv
// rtl/uds_pkg.sv - shared types and constants for the up/downsample datapath
package uds_pkg;

   localparam int ROW_W = 8*32;

   localparam logic FUNC_UPSAMPLE   = 1'b0;
   localparam logic FUNC_DOWNSAMPLE = 1'b1;

   typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} coll_state_e;

   function automatic int nrows(input int a);
      return 2*(a-8)/8;
   endfunction

endpackage

// File: rtl/uds_frame_fifo.sv
// rtl/uds_frame_fifo.sv - register FIFO of whole result frames plus their row counts
module uds_frame_fifo
   import uds_pkg::*;
#(
   parameter  int FW    = ROW_W,
   parameter  int DEPTH = 2,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [FW-1:0] push_data,
   input  logic [3:0]    push_rows,
   input  logic          pop,
   output logic [FW-1:0] head_data,
   output logic [3:0]    head_rows,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [FW-1:0] data_q [DEPTH];
   logic [FW-1:0] data_d [DEPTH];
   logic [3:0]    rows_q [DEPTH];
   logic [3:0]    rows_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_pop;

   always_comb begin
      data_d   = data_q;
      rows_d   = rows_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_pop   = pop && (count_q != '0);
      if (push) begin
         data_d[wr_ptr_q] = push_data;
         rows_d[wr_ptr_q] = push_rows;
         wr_ptr_d         = wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      // A push into the slot being popped keeps the occupancy unchanged
      if (push && !do_pop)      count_d = count_q + 1'b1;
      else if (!push && do_pop) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      data_q <= data_d;
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) rows_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rows_q   <= rows_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_data = data_q[rd_ptr_q];
   assign head_rows = rows_q[rd_ptr_q];
   assign full      = (count_q == DEPTH_C);
   assign empty     = (count_q == '0);
   assign count     = count_q;

endmodule

// File: rtl/uds_odata_collector.sv
// rtl/uds_odata_collector.sv - buffers engine result frames and drains them as addressed row beats
// Optional UDS_COLLECT_STATS_EN adds frames_done / stall_cycles counters.
module uds_odata_collector
   import uds_pkg::*;
#(
   parameter int A     = 64,
   parameter int DW    = 32,
   parameter int DEPTH = 2,
   parameter int AW    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [AW-1:0]         base_addr,
   input  logic [AW-1:0]         stride,
   input  logic [2*(A-8)*DW-1:0] in_data,
   input  logic                  in_valid,
   input  logic [3:0]            in_rows,
   output logic [8*DW-1:0]       out_row,
   output logic [AW-1:0]         out_addr,
   output logic                  out_valid,
   output logic                  out_last,
   input  logic                  out_ready,
   output logic                  hold_req,
   output logic                  overflow
`ifdef UDS_COLLECT_STATS_EN
   ,
   output logic [15:0]           frames_done,
   output logic [15:0]           stall_cycles
`endif
);

   localparam int RW = 8*DW;
   localparam int FW = 2*(A-8)*DW;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [3:0] NROWS_C = 4'(nrows(A));

   coll_state_e   state_q, state_d;
   logic [3:0]    row_q, row_d;
   logic [AW-1:0] addr_q, addr_d, frame_base_q, frame_base_d, stride_q, stride_d;
   logic          start_pend_q, start_pend_d, overflow_q, overflow_d;

   logic [FW-1:0] head_data;
   logic [3:0]    head_rows, rows_clamped;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   logic          is_last, hs, last_hs, push;

   always_comb begin
      rows_clamped = (in_rows == 4'd0 || in_rows > NROWS_C) ? NROWS_C : in_rows;
      is_last      = (state_q == DRAIN) && (row_q == head_rows - 4'd1);
      hs           = (state_q == DRAIN) && out_ready;
      last_hs      = hs && is_last;
      push         = in_valid && (!fifo_full || last_hs);
   end

   uds_frame_fifo #(.FW(FW), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (in_data),
      .push_rows (rows_clamped),
      .pop       (last_hs),
      .head_data (head_data),
      .head_rows (head_rows),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      addr_d       = addr_q;
      frame_base_d = frame_base_q;
      stride_d     = stride_q;
      start_pend_d = start_pend_q;
      overflow_d   = overflow_q;
      case (state_q)
         IDLE:    if (push || !fifo_empty) state_d = DRAIN;
         DRAIN:   if (last_hs && fifo_count == CW'(1) && !push) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (hs && !is_last) begin
         row_d  = row_q + 4'd1;
         addr_d = addr_q + 1'b1;
      end
      // A start seen mid-frame only retargets the frames queued behind it
      if (last_hs) begin
         row_d = 4'd0;
         if (start_pend_q) begin
            addr_d       = frame_base_q;
            start_pend_d = 1'b0;
         end else begin
            frame_base_d = frame_base_q + stride_q;
            addr_d       = frame_base_d;
         end
      end
      if (start) begin
         stride_d     = stride;
         frame_base_d = base_addr;
         overflow_d   = 1'b0;
         start_pend_d = 1'b0;
         if (state_q == IDLE || last_hs) addr_d = base_addr;
         else start_pend_d = 1'b1;
      end
      if (in_valid && !push) overflow_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         row_q        <= '0;
         addr_q       <= '0;
         frame_base_q <= '0;
         stride_q     <= '0;
         start_pend_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         addr_q       <= addr_d;
         frame_base_q <= frame_base_d;
         stride_q     <= stride_d;
         start_pend_q <= start_pend_d;
         overflow_q   <= overflow_d;
      end
   end

   assign out_valid = (state_q == DRAIN);
   assign out_last  = is_last;
   assign out_row   = out_valid ? head_data[int'(row_q)*RW +: RW] : '0;
   assign out_addr  = addr_q;
   assign hold_req  = fifo_full;
   assign overflow  = overflow_q;

`ifdef UDS_COLLECT_STATS_EN
   logic [15:0] frames_done_q, frames_done_d, stall_cycles_q, stall_cycles_d;

   always_comb begin
      frames_done_d  = frames_done_q;
      stall_cycles_d = stall_cycles_q;
      if (last_hs) frames_done_d = frames_done_q + 16'd1;
      if (out_valid && !out_ready && stall_cycles_q != 16'hFFFF)
         stall_cycles_d = stall_cycles_q + 16'd1;
      if (start) begin
         frames_done_d  = '0;
         stall_cycles_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frames_done_q  <= '0;
         stall_cycles_q <= '0;
      end else begin
         frames_done_q  <= frames_done_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign frames_done  = frames_done_q;
   assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_uds_odata_collector.sv
// tb/tb_uds_odata_collector.sv - directed self-checking bench for uds_odata_collector
module tb_uds_odata_collector;

   logic          clk = 1'b0;
   logic          rst, start, in_valid, out_ready;
   logic [15:0]   base_addr, stride;
   logic [3583:0] in_data;
   logic [3:0]    in_rows;
   logic [255:0]  out_row;
   logic [15:0]   out_addr;
   logic          out_valid, out_last, hold_req, overflow;
`ifdef UDS_COLLECT_STATS_EN
   logic [15:0]   frames_done, stall_cycles;
`endif

   uds_odata_collector #(.A(64), .DW(32), .DEPTH(2), .AW(16)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .stride(stride),
      .in_data(in_data), .in_valid(in_valid), .in_rows(in_rows),
      .out_row(out_row), .out_addr(out_addr), .out_valid(out_valid), .out_last(out_last),
      .out_ready(out_ready), .hold_req(hold_req), .overflow(overflow)
`ifdef UDS_COLLECT_STATS_EN
      , .frames_done(frames_done), .stall_cycles(stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   logic [15:0]  q_addr [$];
   logic [255:0] q_row [$];
   logic         q_last [$];
   int           q_cyc [$];
   int           hold_err, valid_cycles;
   logic         hold_seen, prev_stall, prev_last;
   logic [255:0] prev_row;
   logic [15:0]  prev_addr;

   function automatic logic [255:0] mkrow(input int fid, input int r);
      logic [255:0] v;
      for (int e = 0; e < 8; e++) v[e*32 +: 32] = {8'hC0, 8'(fid), 8'(r), 8'(e)};
      return v;
   endfunction

   function automatic logic [3583:0] mkframe(input int fid);
      logic [3583:0] v;
      for (int r = 0; r < 14; r++) v[r*256 +: 256] = mkrow(fid, r);
      return v;
   endfunction

   task automatic clear_rec();
      q_addr.delete(); q_row.delete(); q_last.delete(); q_cyc.delete();
      hold_err = 0; valid_cycles = 0; hold_seen = 1'b0; prev_stall = 1'b0;
   endtask

   // Records handshakes and stall-stability violations, then advances one cycle
   task automatic tick();
      if (hold_req) hold_seen = 1'b1;
      if (out_valid) valid_cycles++;
      if (prev_stall && (!out_valid || out_row !== prev_row || out_addr !== prev_addr || out_last !== prev_last))
         hold_err++;
      if (out_valid && out_ready) begin
         q_addr.push_back(out_addr); q_row.push_back(out_row);
         q_last.push_back(out_last); q_cyc.push_back(cyc);
      end
      prev_stall = out_valid && !out_ready;
      prev_row = out_row; prev_addr = out_addr; prev_last = out_last;
      @(posedge clk); #1;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_rows = 4'd0; in_data = '0; base_addr = '0; stride = '0;
      tick(); tick();
      rst = 1'b0;
      clear_rec();
   endtask

   task automatic pulse_start(input logic [15:0] b, input logic [15:0] s);
      start = 1'b1; base_addr = b; stride = s;
      tick();
      start = 1'b0;
   endtask

   task automatic push_frame(input int fid, input int rows);
      in_valid = 1'b1; in_data = mkframe(fid); in_rows = 4'(rows);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; base_addr = 16'h1234; stride = 16'h0001;
      in_valid = 1'b1; in_data = mkframe(0); in_rows = 4'd3; out_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_addr !== 16'h0) begin failures++; $display("FAIL reset_out_addr got=%h exp=0000", out_addr); end
      checks++; if (out_row !== 256'h0) begin failures++; $display("FAIL reset_out_row got=%h exp=0", out_row[31:0]); end
      checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
      checks++; if (hold_req !== 1'b0) begin failures++; $display("FAIL reset_hold_req got=%b exp=0", hold_req); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
      rst = 1'b0; start = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_no_frame got=%b exp=0", out_valid); end
   endtask

   task automatic test_single_frame();
      int c0;
      do_reset();
      pulse_start(16'h0100, 16'h0020);
      out_ready = 1'b1;
      c0 = cyc;
      push_frame(1, 14);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_latency got=%b exp=1", out_valid); end
      run(20);
      checks++; if (q_addr.size() != 14) begin failures++; $display("FAIL single_count got=%0d exp=14", q_addr.size()); end
      checks++; if (valid_cycles != 14) begin failures++; $display("FAIL single_valid_cycles got=%0d exp=14", valid_cycles); end
      for (int i = 0; i < 14; i++) begin
         checks++;
         if (i >= q_addr.size()) begin failures++; $display("FAIL single_beat%0d missing", i); end
         else if (q_addr[i] !== 16'(16'h0100 + i) || q_row[i] !== mkrow(1, i) || q_last[i] !== (i == 13) || q_cyc[i] != c0 + 1 + i) begin
            failures++;
            $display("FAIL single_beat%0d addr=%h exp=%h last=%b exp=%b cyc=%0d exp=%0d", i, q_addr[i], 16'(16'h0100 + i), q_last[i], (i == 13), q_cyc[i], c0 + 1 + i);
         end
      end
   endtask

   task automatic test_back_to_back();
      int c0;
      logic [15:0] ea [8] = '{16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0120, 16'h0121, 16'h0122, 16'h0123};
      do_reset();
      pulse_start(16'h0100, 16'h0020);
      out_ready = 1'b1;
      c0 = cyc;
      push_frame(2, 4);
      run(3);
      push_frame(3, 4);
      run(10);
      checks++; if (q_addr.size() != 8) begin failures++; $display("FAIL b2b_count got=%0d exp=8", q_addr.size()); end
      checks++; if (hold_seen !== 1'b0) begin failures++; $display("FAIL b2b_hold_req got=%b exp=0", hold_seen); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (i >= q_addr.size()) begin failures++; $display("FAIL b2b_beat%0d missing", i); end
         else if (q_addr[i] !== ea[i] || q_row[i] !== mkrow(2 + i/4, i%4) || q_last[i] !== (i%4 == 3) || q_cyc[i] != c0 + 1 + i) begin
            failures++;
            $display("FAIL b2b_beat%0d addr=%h exp=%h last=%b cyc=%0d exp=%0d", i, q_addr[i], ea[i], q_last[i], q_cyc[i], c0 + 1 + i);
         end
      end
   endtask

   task automatic test_ready_toggle();
      do_reset();
      pulse_start(16'h0200, 16'h0010);
      out_ready = 1'b1;
      push_frame(4, 3);
      for (int k = 1; k < 12; k++) begin
         out_ready = (k % 2 == 0);
         tick();
      end
      checks++; if (q_addr.size() != 3) begin failures++; $display("FAIL toggle_count got=%0d exp=3", q_addr.size()); end
      checks++; if (hold_err != 0) begin failures++; $display("FAIL toggle_stable got=%0d exp=0", hold_err); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (i >= q_addr.size()) begin failures++; $display("FAIL toggle_beat%0d missing", i); end
         else if (q_addr[i] !== 16'(16'h0200 + i) || q_row[i] !== mkrow(4, i) || q_last[i] !== (i == 2)) begin
            failures++; $display("FAIL toggle_beat%0d addr=%h exp=%h last=%b", i, q_addr[i], 16'(16'h0200 + i), q_last[i]);
         end
      end
`ifdef UDS_COLLECT_STATS_EN
      checks++; if (stall_cycles !== 16'd3) begin failures++; $display("FAIL toggle_stall_cycles got=%0d exp=3", stall_cycles); end
      checks++; if (frames_done !== 16'd1) begin failures++; $display("FAIL toggle_frames_done got=%0d exp=1", frames_done); end
`endif
   endtask

   task automatic test_overflow();
      logic [15:0] ea [4] = '{16'h0300, 16'h0301, 16'h0340, 16'h0341};
      do_reset();
      pulse_start(16'h0300, 16'h0040);
      out_ready = 1'b0;
      push_frame(5, 2);
      push_frame(6, 2);
      checks++; if (hold_req !== 1'b1) begin failures++; $display("FAIL ovf_hold_full got=%b exp=1", hold_req); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_before_drop got=%b exp=0", overflow); end
      push_frame(7, 2);
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_after_drop got=%b exp=1", overflow); end
      out_ready = 1'b1;
      run(10);
      checks++; if (q_addr.size() != 4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", q_addr.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= q_addr.size()) begin failures++; $display("FAIL ovf_beat%0d missing", i); end
         else if (q_addr[i] !== ea[i] || q_row[i] !== mkrow(5 + i/2, i%2) || q_last[i] !== (i%2 == 1)) begin
            failures++; $display("FAIL ovf_beat%0d addr=%h exp=%h last=%b", i, q_addr[i], ea[i], q_last[i]);
         end
      end
      checks++; if (hold_req !== 1'b0) begin failures++; $display("FAIL ovf_hold_drained got=%b exp=0", hold_req); end
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
      pulse_start(16'h0000, 16'h0000);
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_start_clear got=%b exp=0", overflow); end
   endtask

   task automatic test_full_coincident();
      logic [15:0] ea [5] = '{16'h0400, 16'h0401, 16'h0408, 16'h0409, 16'h0410};
      int          ef [5] = '{8, 8, 9, 9, 10};
      int          er [5] = '{0, 1, 0, 1, 0};
      logic        el [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      do_reset();
      pulse_start(16'h0400, 16'h0008);
      out_ready = 1'b0;
      push_frame(8, 2);
      push_frame(9, 2);
      out_ready = 1'b1;
      tick();
      push_frame(10, 1);
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL coinc_overflow got=%b exp=0", overflow); end
      checks++; if (hold_req !== 1'b1) begin failures++; $display("FAIL coinc_count_full got=%b exp=1", hold_req); end
      run(10);
      checks++; if (q_addr.size() != 5) begin failures++; $display("FAIL coinc_count got=%0d exp=5", q_addr.size()); end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (i >= q_addr.size()) begin failures++; $display("FAIL coinc_beat%0d missing", i); end
         else if (q_addr[i] !== ea[i] || q_row[i] !== mkrow(ef[i], er[i]) || q_last[i] !== el[i]) begin
            failures++; $display("FAIL coinc_beat%0d addr=%h exp=%h last=%b exp=%b", i, q_addr[i], ea[i], q_last[i], el[i]);
         end
      end
   endtask

   task automatic test_start_mid();
      logic [15:0] ea [7] = '{16'h0700, 16'h0701, 16'h0702, 16'h0703, 16'h0800, 16'h0801, 16'h0804};
      int          ef [7] = '{16, 16, 16, 16, 17, 17, 18};
      int          er [7] = '{0, 1, 2, 3, 0, 1, 0};
      do_reset();
      pulse_start(16'h0700, 16'h0010);
      out_ready = 1'b1;
      push_frame(16, 4);
      tick();
      start = 1'b1; base_addr = 16'h0800; stride = 16'h0004;
      push_frame(17, 2);
      start = 1'b0;
      run(8);
      push_frame(18, 1);
      run(4);
      checks++; if (q_addr.size() != 7) begin failures++; $display("FAIL startmid_count got=%0d exp=7", q_addr.size()); end
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (i >= q_addr.size()) begin failures++; $display("FAIL startmid_beat%0d missing", i); end
         else if (q_addr[i] !== ea[i] || q_row[i] !== mkrow(ef[i], er[i])) begin
            failures++; $display("FAIL startmid_beat%0d addr=%h exp=%h", i, q_addr[i], ea[i]);
         end
      end
   endtask

   task automatic test_clamp_wrap();
      logic [15:0] ea;
      do_reset();
      pulse_start(16'hFFFE, 16'h0003);
      out_ready = 1'b1;
      push_frame(14, 0);
      run(3);
      push_frame(15, 15);
      run(30);
      checks++; if (q_addr.size() != 28) begin failures++; $display("FAIL clamp_count got=%0d exp=28", q_addr.size()); end
      for (int i = 0; i < 28; i++) begin
         ea = (i < 14) ? 16'(16'hFFFE + i) : 16'(16'h0001 + (i - 14));
         checks++;
         if (i >= q_addr.size()) begin failures++; $display("FAIL clamp_beat%0d missing", i); end
         else if (q_addr[i] !== ea || q_row[i] !== mkrow(14 + i/14, i%14) || q_last[i] !== (i%14 == 13)) begin
            failures++; $display("FAIL clamp_beat%0d addr=%h exp=%h last=%b", i, q_addr[i], ea, q_last[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      pulse_start(16'h0500, 16'h0000);
      out_ready = 1'b1;
      push_frame(11, 14);
      run(5);
      checks++; if (out_addr !== 16'h0505) begin failures++; $display("FAIL rstmid_beat5_addr got=%h exp=0505", out_addr); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
      checks++; if (out_addr !== 16'h0000) begin failures++; $display("FAIL rstmid_addr got=%h exp=0000", out_addr); end
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_empty got=%b exp=0", out_valid); end
      clear_rec();
      push_frame(12, 2);
      run(4);
      pulse_start(16'h0600, 16'h0000);
      push_frame(13, 1);
      run(3);
      checks++; if (q_addr.size() != 3) begin failures++; $display("FAIL rstmid_count got=%0d exp=3", q_addr.size()); end
      if (q_addr.size() == 3) begin
         checks++; if (q_addr[0] !== 16'h0000 || q_row[0] !== mkrow(12, 0)) begin failures++; $display("FAIL rstmid_after0 addr=%h exp=0000", q_addr[0]); end
         checks++; if (q_addr[1] !== 16'h0001 || q_row[1] !== mkrow(12, 1)) begin failures++; $display("FAIL rstmid_after1 addr=%h exp=0001", q_addr[1]); end
         checks++; if (q_addr[2] !== 16'h0600 || q_row[2] !== mkrow(13, 0)) begin failures++; $display("FAIL rstmid_reload addr=%h exp=0600", q_addr[2]); end
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_ready_toggle();
      test_overflow();
      test_full_coincident();
      test_start_mid();
      test_clamp_wrap();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
